commit_perf_sequencer: RTL and testbench
========================================

Name: commit_perf_sequencer

Overview:
- Sequences the per-instruction commit/trace path of the multi-cycle core. It tracks valid/ready fire events of the five stages: ifu/icache, idu, exu, lsu, wbu.
- Measures per-stage cycle cost and icache miss penalty, and carries the costs alongside the instruction through a record pipeline.
- Issues exactly one registered sync_en pulse per committed instruction to the simulation state syncer, with the cost fields aligned to that pulse.
- Also owns sim-end halting, the commit watchdog and protocol-error detection.

Parameters:
- CNT_W, 64, width of every cycle/instruction counter (saturating).
- WDOG_LIMIT, 0, cycles without a commit before timeout is raised; 0 disables the watchdog.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- stage_in_fire  in  5  per-stage input handshake fire; bit0 = ifu … bit4 = wbu.
- stage_out_fire  in  5  per-stage output handshake fire.
- icache_need  in  1  the fetch accesses the icache; sampled at stage_in_fire[0].
- icache_miss_begin  in  1  refill started, pulse.
- icache_miss_end  in  1  refill finished, pulse.
- sim_end_in  in  1  the instruction committing this cycle is the end-of-simulation trap.
- sync_en  out  1  one-cycle commit pulse to the syncer.
- cost_stage  out  5*CNT_W  per-stage cost of the committed instruction; field i = stage i.
- icache_miss_cost  out  CNT_W  miss penalty of the committed instruction.
- icache_hit  out  1  icache_need && no miss occurred.
- icache_used  out  1  latched icache_need.
- sim_end_out  out  1  aligned with sync_en.
- instret  out  CNT_W  committed instruction count.
- halted  out  1  sticky after the sim-end commit.
- timeout  out  1  sticky watchdog flag.
- proto_err  out  1  sticky handshake-violation flag.

Behaviour:
- Reset: all outputs and registers are 0; every stage is IDLE.
- Per-stage FSM, states IDLE and BUSY. Counter cnt[i] behaves as follows:
  - in_fire with no out_fire: go to BUSY, cnt = 1.
  - In BUSY: cnt increments each cycle, saturating at all-ones.
  - out_fire: cost = cnt + 1 if BUSY; cost = 1 if in_fire and out_fire fall in the same cycle while IDLE (single-cycle stage).
  - After out_fire: return to IDLE.
  - in_fire together with out_fire while BUSY: finish the old instruction and restart with cnt = 1.
- Record pipeline:
  - rec[i] holds the costs of stages < i plus the icache fields.
  - On out_fire[i], rec[i] with cost_i inserted moves into rec[i+1]. The matching in_fire[i+1] is expected the same cycle.
  - On out_fire[4], the complete record moves into the output registers.
- Icache accounting, in stage 0:
  - A miss counter starts at icache_miss_begin and counts cycles up to and including icache_miss_end.
  - miss_cost = 0 when there is no miss.
  - hit = icache_need && !miss_seen.
  - A begin without icache_need raises proto_err.
- Commit:
  - The cycle after out_fire[4] and !halted, drive sync_en = 1 with the record outputs and sim_end_out = sim_end_in registered.
  - instret increments in the same cycle as sync_en, saturating.
  - The record outputs hold their value until the next commit.
- Halting:
  - The sync_en with sim_end_out = 1 sets halted.
  - While halted, sync_en, instret, the watchdog and cost counters are frozen, and later fires are ignored.
- Watchdog:
  - Counts cycles since the last sync_en (or since reset).
  - Reaching WDOG_LIMIT sets timeout; it is cleared only by reset.
- proto_err (sticky) is set by any of:
  - out_fire[i] while IDLE without a same-cycle in_fire[i];
  - in_fire[i+1] not coincident with out_fire[i];
  - icache_miss_end with no miss in progress.
- The offending event is otherwise ignored.
- Reset asserted mid-instruction discards all records; no sync_en is emitted the following cycle.

Decomposition:
- Shared package perf_pkg holds:
  - STAGE_IFU..STAGE_WBU index constants (0..4) and NSTAGE = 5;
  - typedef perf_rec_t { cost[NSTAGE], miss_cost, icache_used, icache_hit };
  - typedef stage_state_e { IDLE, BUSY }.
- Sub-module stage_cycle_counter is instantiated 5 times. It contains the FSM, saturating counter and violation output for one stage.

Test Plan:
- Single instruction:
  - Stimulus: stages fire with lengths 3, 1, 2, 5, 1 cycles; icache_need = 1; no miss.
  - Response: one sync_en; cost_stage = {1, 5, 2, 1, 3} (wbu..ifu); icache_hit = 1; icache_miss_cost = 0; instret = 1.
- Icache miss:
  - Stimulus: miss_begin in cycle 1 of fetch, miss_end in cycle 8, out_fire[0] in cycle 9.
  - Response: icache_miss_cost = 8; icache_hit = 0; cost ifu = 10.
- Back-to-back single-cycle instructions:
  - Stimulus: all stages fire every cycle for 4 instructions.
  - Response: 4 consecutive sync_en pulses, every cost = 1, instret = 4.
- Sim end:
  - Stimulus: sim_end_in with the 3rd commit, then further fires.
  - Response: sync_en count stays 3; halted = 1; sim_end_out high on the 3rd pulse; instret frozen at 3.
- Watchdog:
  - Stimulus: WDOG_LIMIT = 16, ifu stalled in BUSY.
  - Response: timeout rises exactly 16 cycles after reset; sync_en never asserts.
- Protocol error and reset:
  - Stimulus: out_fire[2] while IDLE.
  - Response: proto_err = 1 and no commit.
  - Then assert reset mid-exu: all outputs 0 next cycle and no stale sync_en.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared definitions for the commit/trace performance sequencer: stage indices,
// the per-instruction cost record and the per-stage FSM state encoding.
package perf_pkg;

  localparam int NSTAGE    = 5;
  localparam int STAGE_IFU = 0;
  localparam int STAGE_IDU = 1;
  localparam int STAGE_EXU = 2;
  localparam int STAGE_LSU = 3;
  localparam int STAGE_WBU = 4;

  // Record fields are stored at this fixed width; CNT_W must not exceed it.
  localparam int REC_W = 64;

  typedef logic [REC_W-1:0] recCnt_t;

  typedef struct packed {
    recCnt_t [NSTAGE-1:0] cost;
    recCnt_t              missCost;
    logic                 icacheUsed;
    logic                 icacheHit;
  } perf_rec_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stage_state_e;

endpackage

// File: rtl/stage_cycle_counter.sv
// One stage's IDLE/BUSY tracker: counts cycles between input and output fire
// and reports the cost on completion, or a violation for an unmatched output fire.
module stage_cycle_counter
  import perf_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             inFire,
  input  logic             outFire,
  output logic             done,
  output logic [CNT_W-1:0] cost,
  output logic             violation,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_state_e     state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // While frozen nothing moves and no event is reported.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    done      = 1'b0;
    cost      = '0;
    violation = 1'b0;
    if (enable) begin
      case (state)
        IDLE: begin
          if (inFire && outFire) begin
            done = 1'b1;
            cost = CNT_ONE;
          end else if (inFire) begin
            stateNext = BUSY;
            cntNext   = CNT_ONE;
          end else if (outFire) begin
            violation = 1'b1;
          end
        end
        BUSY: begin
          cntNext = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
          if (outFire) begin
            done = 1'b1;
            cost = cntNext;
            if (inFire) begin
              cntNext = CNT_ONE;
            end else begin
              stateNext = IDLE;
              cntNext   = '0;
            end
          end
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/commit_perf_sequencer.sv
// Tracks the five stage handshakes, carries per-instruction costs down a record
// pipeline and emits one registered sync_en per commit, plus halt/watchdog/protocol flags.
module commit_perf_sequencer
  import perf_pkg::*;
#(
  parameter int CNT_W      = 64,
  parameter int WDOG_LIMIT = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NSTAGE-1:0]       stage_in_fire,
  input  logic [NSTAGE-1:0]       stage_out_fire,
  input  logic                    icache_need,
  input  logic                    icache_miss_begin,
  input  logic                    icache_miss_end,
  input  logic                    sim_end_in,
  output logic                    sync_en,
  output logic [NSTAGE*CNT_W-1:0] cost_stage,
  output logic [CNT_W-1:0]        icache_miss_cost,
  output logic                    icache_hit,
  output logic                    icache_used,
  output logic                    sim_end_out,
  output logic [CNT_W-1:0]        instret,
  output logic                    halted,
  output logic                    timeout,
  output logic                    proto_err
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(WDOG_LIMIT);

  logic                active;
  logic [NSTAGE-1:0]   inOk, chainErr, done, violation, busy;
  logic [CNT_W-1:0]    stageCost [NSTAGE];

  assign active = !halted;

  // A downstream input fire only counts when it lines up with the upstream output fire.
  always_comb begin
    inOk     = '0;
    chainErr = '0;
    inOk[0]  = active && stage_in_fire[0];
    for (int i = 1; i < NSTAGE; i++) begin
      inOk[i]     = active && stage_in_fire[i] && stage_out_fire[i-1];
      chainErr[i] = active && stage_in_fire[i] && !stage_out_fire[i-1];
    end
  end

  for (genvar g = 0; g < NSTAGE; g++) begin : gStage
    stage_cycle_counter #(.CNT_W(CNT_W)) uCounter (
      .clock     (clock),
      .reset     (reset),
      .enable    (active),
      .inFire    (inOk[g]),
      .outFire   (stage_out_fire[g]),
      .done      (done[g]),
      .cost      (stageCost[g]),
      .violation (violation[g]),
      .busy      (busy[g])
    );
  end

  logic             needLatched, missActive, missSeen;
  logic [CNT_W-1:0] missCnt;
  logic             baseNeed, baseActive, baseSeen;
  logic [CNT_W-1:0] baseCnt;
  logic             curActive, curSeen;
  logic [CNT_W-1:0] curCnt;
  logic             beginErr, endErr, restartFetch;

  // A fetch entering an idle IFU owns this cycle's miss events; on a restart the
  // events still belong to the fetch that is leaving.
  always_comb begin
    baseNeed   = needLatched;
    baseActive = missActive;
    baseSeen   = missSeen;
    baseCnt    = missCnt;
    if (inOk[0] && !busy[0]) begin
      baseNeed   = icache_need;
      baseActive = 1'b0;
      baseSeen   = 1'b0;
      baseCnt    = '0;
    end
    curActive = baseActive;
    curSeen   = baseSeen;
    curCnt    = baseCnt;
    beginErr  = active && icache_miss_begin && !baseNeed;
    if (active && baseActive) begin
      curCnt = (baseCnt == CNT_MAX) ? baseCnt : baseCnt + CNT_ONE;
    end
    if (active && icache_miss_begin && baseNeed) begin
      curActive = 1'b1;
      curSeen   = 1'b1;
      curCnt    = CNT_ONE;
    end
    endErr = active && icache_miss_end && !curActive;
    if (active && icache_miss_end) begin
      curActive = 1'b0;
    end
    restartFetch = inOk[0] && busy[0] && stage_out_fire[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      needLatched <= 1'b0;
      missActive  <= 1'b0;
      missSeen    <= 1'b0;
      missCnt     <= '0;
    end else if (restartFetch) begin
      needLatched <= icache_need;
      missActive  <= 1'b0;
      missSeen    <= 1'b0;
      missCnt     <= '0;
    end else begin
      needLatched <= baseNeed;
      missActive  <= curActive;
      missSeen    <= curSeen;
      missCnt     <= curCnt;
    end
  end

  perf_rec_t rec    [1:NSTAGE-1];
  perf_rec_t finRec [NSTAGE];

  // finRec[i] is the record of the instruction leaving stage i this cycle; a
  // single-cycle pass through an idle stage takes the upstream record directly.
  always_comb begin
    finRec[0]                = '0;
    finRec[0].missCost       = recCnt_t'(curCnt);
    finRec[0].icacheUsed     = baseNeed;
    finRec[0].icacheHit      = baseNeed && !curSeen;
    finRec[0].cost[STAGE_IFU] = recCnt_t'(stageCost[0]);
    for (int i = 1; i < NSTAGE; i++) begin
      finRec[i]         = (inOk[i] && !busy[i]) ? finRec[i-1] : rec[i];
      finRec[i].cost[i] = recCnt_t'(stageCost[i]);
    end
  end

  logic [CNT_W-1:0] wdog, wdogNext;

  assign wdogNext = sync_en ? '0 : ((wdog == CNT_MAX) ? wdog : wdog + CNT_ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < NSTAGE; i++) begin
        rec[i] <= '0;
      end
      sync_en          <= 1'b0;
      cost_stage       <= '0;
      icache_miss_cost <= '0;
      icache_hit       <= 1'b0;
      icache_used      <= 1'b0;
      sim_end_out      <= 1'b0;
      instret          <= '0;
      halted           <= 1'b0;
      timeout          <= 1'b0;
      proto_err        <= 1'b0;
      wdog             <= '0;
    end else begin
      // A stage keeps a record when an instruction enters and stays there.
      for (int i = 1; i < NSTAGE; i++) begin
        if (inOk[i] && (busy[i] == stage_out_fire[i])) begin
          rec[i] <= finRec[i-1];
        end
      end
      sync_en <= done[STAGE_WBU];
      if (done[STAGE_WBU]) begin
        for (int i = 0; i < NSTAGE; i++) begin
          cost_stage[i*CNT_W +: CNT_W] <= finRec[STAGE_WBU].cost[i][CNT_W-1:0];
        end
        icache_miss_cost <= finRec[STAGE_WBU].missCost[CNT_W-1:0];
        icache_hit       <= finRec[STAGE_WBU].icacheHit;
        icache_used      <= finRec[STAGE_WBU].icacheUsed;
        sim_end_out      <= sim_end_in;
        instret          <= (instret == CNT_MAX) ? instret : instret + CNT_ONE;
        if (sim_end_in) begin
          halted <= 1'b1;
        end
      end
      if (active) begin
        wdog <= wdogNext;
        if (WDOG_LIMIT != 0 && wdogNext >= WDOG_LIM) begin
          timeout <= 1'b1;
        end
      end
      proto_err <= proto_err | (|violation) | (|chainErr) | beginErr | endErr;
    end
  end

endmodule

// File: tb/tb_commit_perf_sequencer.sv
// Directed bench for commit_perf_sequencer: walks single, miss, back-to-back,
// sim-end, watchdog and protocol/reset scenarios with hand-computed expectations.
module tb_commit_perf_sequencer;

  localparam int CNT_W = 64;

  logic             clock;
  logic             reset;
  logic [4:0]       stage_in_fire, stage_out_fire;
  logic             icache_need, icache_miss_begin, icache_miss_end, sim_end_in;
  logic             sync_en;
  logic [5*CNT_W-1:0] cost_stage;
  logic [CNT_W-1:0] icache_miss_cost, instret;
  logic             icache_hit, icache_used, sim_end_out, halted, timeout, proto_err;

  int vectors     = 0;
  int miscompares = 0;
  int syncCount   = 0;

  commit_perf_sequencer #(.CNT_W(CNT_W), .WDOG_LIMIT(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .stage_in_fire     (stage_in_fire),
    .stage_out_fire    (stage_out_fire),
    .icache_need       (icache_need),
    .icache_miss_begin (icache_miss_begin),
    .icache_miss_end   (icache_miss_end),
    .sim_end_in        (sim_end_in),
    .sync_en           (sync_en),
    .cost_stage        (cost_stage),
    .icache_miss_cost  (icache_miss_cost),
    .icache_hit        (icache_hit),
    .icache_used       (icache_used),
    .sim_end_out       (sim_end_out),
    .instret           (instret),
    .halted            (halted),
    .timeout           (timeout),
    .proto_err         (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle with the given inputs; outputs are sampled 1ns after the edge.
  task automatic applyStimulus(input logic [4:0] inF, input logic [4:0] outF,
                               input logic need = 1'b0, input logic mBegin = 1'b0,
                               input logic mEnd = 1'b0, input logic simEnd = 1'b0);
    stage_in_fire     = inF;
    stage_out_fire    = outF;
    icache_need       = need;
    icache_miss_begin = mBegin;
    icache_miss_end   = mEnd;
    sim_end_in        = simEnd;
    @(posedge clock);
    #1;
    if (sync_en) syncCount++;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCosts(input string tag, input logic [63:0] c0, input logic [63:0] c1,
                            input logic [63:0] c2, input logic [63:0] c3, input logic [63:0] c4);
    checkOutput({tag, ".ifu"}, cost_stage[0*CNT_W +: CNT_W], c0);
    checkOutput({tag, ".idu"}, cost_stage[1*CNT_W +: CNT_W], c1);
    checkOutput({tag, ".exu"}, cost_stage[2*CNT_W +: CNT_W], c2);
    checkOutput({tag, ".lsu"}, cost_stage[3*CNT_W +: CNT_W], c3);
    checkOutput({tag, ".wbu"}, cost_stage[4*CNT_W +: CNT_W], c4);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(5'b0, 5'b0);
    reset = 1'b0;
    syncCount = 0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(5'b0, 5'b0);
    applyStimulus(5'b0, 5'b0);
    reset = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst.sync_en", 64'(sync_en), 64'd0);
    checkOutput("rst.instret", instret, 64'd0);
    checkOutput("rst.cost_any", 64'(|cost_stage), 64'd0);
    checkOutput("rst.halted", 64'(halted), 64'd0);
    checkOutput("rst.timeout", 64'(timeout), 64'd0);
    checkOutput("rst.proto_err", 64'(proto_err), 64'd0);
    checkOutput("rst.icache_used", 64'(icache_used), 64'd0);

    $display("[TB] single instruction 3/1/2/5/1");
    resetDut();
    applyStimulus(5'b00001, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00000);
    applyStimulus(5'b00110, 5'b00011);
    applyStimulus(5'b01000, 5'b00100);
    applyStimulus(5'b00000, 5'b00000);
    applyStimulus(5'b00000, 5'b00000);
    applyStimulus(5'b00000, 5'b00000);
    checkOutput("single.pre_sync", 64'(sync_en), 64'd0);
    applyStimulus(5'b10000, 5'b11000);
    checkOutput("single.sync_en", 64'(sync_en), 64'd1);
    checkCosts("single", 64'd3, 64'd1, 64'd2, 64'd5, 64'd1);
    checkOutput("single.hit", 64'(icache_hit), 64'd1);
    checkOutput("single.used", 64'(icache_used), 64'd1);
    checkOutput("single.miss_cost", icache_miss_cost, 64'd0);
    checkOutput("single.instret", instret, 64'd1);
    checkOutput("single.sim_end_out", 64'(sim_end_out), 64'd0);
    applyStimulus(5'b00000, 5'b00000);
    checkOutput("single.sync_drop", 64'(sync_en), 64'd0);
    checkOutput("single.hold_lsu", cost_stage[3*CNT_W +: CNT_W], 64'd5);
    checkOutput("single.sync_count", 64'(syncCount), 64'd1);
    checkOutput("single.proto_err", 64'(proto_err), 64'd0);

    $display("[TB] icache miss");
    resetDut();
    applyStimulus(5'b00001, 5'b00000, 1'b1);
    applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) applyStimulus(5'b00000, 5'b00000);
    applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'b11110, 5'b11111);
    checkOutput("miss.sync_en", 64'(sync_en), 64'd1);
    checkOutput("miss.miss_cost", icache_miss_cost, 64'd8);
    checkOutput("miss.hit", 64'(icache_hit), 64'd0);
    checkOutput("miss.used", 64'(icache_used), 64'd1);
    checkCosts("miss", 64'd10, 64'd1, 64'd1, 64'd1, 64'd1);
    checkOutput("miss.proto_err", 64'(proto_err), 64'd0);

    $display("[TB] back-to-back single-cycle instructions");
    resetDut();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(5'b11111, 5'b11111, 1'b1);
      checkOutput($sformatf("b2b.sync%0d", k), 64'(sync_en), 64'd1);
      checkOutput($sformatf("b2b.instret%0d", k), instret, 64'(k + 1));
    end
    checkCosts("b2b", 64'd1, 64'd1, 64'd1, 64'd1, 64'd1);
    checkOutput("b2b.hit", 64'(icache_hit), 64'd1);
    applyStimulus(5'b00000, 5'b00000);
    checkOutput("b2b.sync_drop", 64'(sync_en), 64'd0);
    checkOutput("b2b.sync_count", 64'(syncCount), 64'd4);

    $display("[TB] sim end");
    resetDut();
    applyStimulus(5'b11111, 5'b11111);
    applyStimulus(5'b11111, 5'b11111);
    checkOutput("simend.halted_early", 64'(halted), 64'd0);
    applyStimulus(5'b11111, 5'b11111, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("simend.sync_en", 64'(sync_en), 64'd1);
    checkOutput("simend.sim_end_out", 64'(sim_end_out), 64'd1);
    checkOutput("simend.halted", 64'(halted), 64'd1);
    applyStimulus(5'b11111, 5'b11111);
    applyStimulus(5'b11111, 5'b11111);
    checkOutput("simend.frozen_sync", 64'(sync_en), 64'd0);
    checkOutput("simend.instret", instret, 64'd3);
    checkOutput("simend.sync_count", 64'(syncCount), 64'd3);
    checkOutput("simend.proto_err", 64'(proto_err), 64'd0);

    $display("[TB] watchdog");
    resetDut();
    applyStimulus(5'b00001, 5'b00000, 1'b1);
    for (int k = 0; k < 14; k++) applyStimulus(5'b00000, 5'b00000);
    checkOutput("wdog.before", 64'(timeout), 64'd0);
    applyStimulus(5'b00000, 5'b00000);
    checkOutput("wdog.at_limit", 64'(timeout), 64'd1);
    applyStimulus(5'b00000, 5'b00000);
    checkOutput("wdog.sticky", 64'(timeout), 64'd1);
    checkOutput("wdog.sync_count", 64'(syncCount), 64'd0);

    $display("[TB] protocol errors and reset");
    resetDut();
    applyStimulus(5'b00000, 5'b00000, 1'b0, 1'b0, 1'b1);
    checkOutput("proto.miss_end", 64'(proto_err), 64'd1);
    resetDut();
    checkOutput("proto.cleared", 64'(proto_err), 64'd0);
    applyStimulus(5'b00000, 5'b00100);
    checkOutput("proto.idle_out", 64'(proto_err), 64'd1);
    applyStimulus(5'b00000, 5'b00000);
    checkOutput("proto.no_commit", 64'(syncCount), 64'd0);
    checkOutput("proto.instret", instret, 64'd0);
    applyStimulus(5'b11111, 5'b11111, 1'b1);
    checkOutput("proto.later_commit", 64'(sync_en), 64'd1);
    applyStimulus(5'b00001, 5'b00000, 1'b1);
    applyStimulus(5'b00110, 5'b00011);
    applyStimulus(5'b00000, 5'b00000);
    reset = 1'b1;
    applyStimulus(5'b11000, 5'b11100);
    reset = 1'b0;
    checkOutput("midrst.sync_en", 64'(sync_en), 64'd0);
    checkOutput("midrst.instret", instret, 64'd0);
    checkOutput("midrst.cost_any", 64'(|cost_stage), 64'd0);
    checkOutput("midrst.proto_err", 64'(proto_err), 64'd0);
    checkOutput("midrst.used", 64'(icache_used), 64'd0);
    applyStimulus(5'b00000, 5'b00000);
    checkOutput("midrst.no_stale", 64'(sync_en), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
